// File: rtl/sar_scan_sequencer.sv
// ---------------------------------------------------------------------------
// sar_scan_sequencer
//
// Scan controller placed in front of the SAR conversion logic and the analog
// input multiplexer. It walks the enabled-channel mask in ascending order. For
// each channel it selects the channel, waits for the mux to settle, pulses the
// SAR start, waits for end-of-conversion and then publishes the result tagged
// with its channel. It runs one-shot scans (trig_i) or continuous scans
// (scan_en_i). A per-conversion watchdog aborts a conversion whose converter
// never answers, so that a hung SAR cannot stall the scan.
//
// Ports
//   clk_i           system clock, rising edge
//   rst_ni          asynchronous active-low reset
//   trig_i          one-shot scan request, sampled only while idle
//   scan_en_i       level, keeps scanning continuously while high
//   ch_mask_i       enabled channels, latched at every scan start
//   err_clr_i       clears timeout_err_o (a coincident timeout wins)
//   sar_start_o     one-cycle start pulse to the SAR logic
//   sar_eoc_i       end-of-conversion, only looked at while converting
//   sar_data_i      SAR result, valid while sar_eoc_i is high
//   mux_sel_o       analog mux channel select
//   result_data_o   last captured conversion result
//   result_ch_o     channel of result_data_o
//   result_valid_o  one-cycle pulse marking a new result
//   scan_done_o     one-cycle pulse at the end of each scan pass
//   busy_o          high whenever the sequencer is not idle
//   timeout_err_o   sticky watchdog flag
//
// Every output is driven straight from a flop.
// ---------------------------------------------------------------------------
module sar_scan_sequencer #(
    parameter int N_CH    = 4,
    parameter int CH_W    = $clog2(N_CH),
    parameter int DATA_W  = 8,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 63
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              trig_i,
    input  logic              scan_en_i,
    input  logic [N_CH-1:0]   ch_mask_i,
    input  logic              err_clr_i,
    output logic              sar_start_o,
    input  logic              sar_eoc_i,
    input  logic [DATA_W-1:0] sar_data_i,
    output logic [CH_W-1:0]   mux_sel_o,
    output logic [DATA_W-1:0] result_data_o,
    output logic [CH_W-1:0]   result_ch_o,
    output logic              result_valid_o,
    output logic              scan_done_o,
    output logic              busy_o,
    output logic              timeout_err_o
);

    // A zero-cycle settle still needs a legal one-bit counter.
    localparam int SET_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_START   = 3'd2,
        S_CONVERT = 3'd3,
        S_NEXT    = 3'd4
    } state_t;

    state_t            state_q;
    logic [N_CH-1:0]   mask_q;
    logic [SET_W-1:0]  settle_q;
    logic [WD_W-1:0]   wd_q;
    logic [CH_W-1:0]   mux_sel_q;
    logic [DATA_W-1:0] result_data_q;
    logic [CH_W-1:0]   result_ch_q;
    logic              sar_start_q;
    logic              result_valid_q;
    logic              scan_done_q;
    logic              busy_q;
    logic              timeout_err_q;

    logic [N_CH-1:0]   above_s;
    logic              has_next_s;
    logic [CH_W-1:0]   next_ch_s;
    logic [CH_W-1:0]   first_ch_s;
    logic              mask_nz_s;
    logic [WD_W-1:0]   wd_d;
    logic              timeout_hit_s;
    logic              timeout_err_d;

    // Index of the lowest set bit; returns 0 for an empty mask.
    function automatic logic [CH_W-1:0] lowest_set(input logic [N_CH-1:0] m);
        logic [CH_W-1:0] r;
        r = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            r = m[i] ? CH_W'(i) : r;
        end
        return r;
    endfunction

    // Channel stepping: the next enabled channel above the current one, and
    // the first channel of the live input mask for a new pass.
    always_comb begin
        above_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            above_s[i] = mask_q[i] & (CH_W'(i) > mux_sel_q);
        end
        has_next_s = |above_s;
        next_ch_s  = lowest_set(above_s);
        first_ch_s = lowest_set(ch_mask_i);
        mask_nz_s  = |ch_mask_i;
    end

    // Watchdog: saturating count of CONVERT cycles; it fires on the cycle the
    // count would reach TIMEOUT without an end-of-conversion. A timeout in the
    // same cycle as err_clr_i keeps the flag set.
    always_comb begin
        if (wd_q == WD_W'(TIMEOUT)) begin
            wd_d = wd_q;
        end else begin
            wd_d = wd_q + WD_W'(1);
        end
        if ((state_q == S_CONVERT) && !sar_eoc_i && (wd_d == WD_W'(TIMEOUT))) begin
            timeout_hit_s = 1'b1;
        end else begin
            timeout_hit_s = 1'b0;
        end
        if (timeout_hit_s) begin
            timeout_err_d = 1'b1;
        end else if (err_clr_i) begin
            timeout_err_d = 1'b0;
        end else begin
            timeout_err_d = timeout_err_q;
        end
    end

    // Sequencer FSM together with all of its registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= S_IDLE;
            mask_q         <= '0;
            settle_q       <= '0;
            wd_q           <= '0;
            mux_sel_q      <= '0;
            result_data_q  <= '0;
            result_ch_q    <= '0;
            sar_start_q    <= 1'b0;
            result_valid_q <= 1'b0;
            scan_done_q    <= 1'b0;
            busy_q         <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            sar_start_q    <= 1'b0;
            result_valid_q <= 1'b0;
            scan_done_q    <= 1'b0;
            timeout_err_q  <= timeout_err_d;
            case (state_q)
                S_IDLE: begin
                    if ((trig_i || scan_en_i) && mask_nz_s) begin
                        mask_q    <= ch_mask_i;
                        mux_sel_q <= first_ch_s;
                        settle_q  <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= (SETTLE == 0) ? S_START : S_SETTLE;
                    end else begin
                        busy_q    <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (settle_q == SET_W'(SETTLE - 1)) begin
                        state_q  <= S_START;
                    end else begin
                        settle_q <= settle_q + SET_W'(1);
                    end
                end
                S_START: begin
                    // The start flop is high for the first CONVERT cycle.
                    sar_start_q <= 1'b1;
                    wd_q        <= '0;
                    state_q     <= S_CONVERT;
                end
                S_CONVERT: begin
                    if (sar_eoc_i) begin
                        result_data_q  <= sar_data_i;
                        result_ch_q    <= mux_sel_q;
                        result_valid_q <= 1'b1;
                        state_q        <= S_NEXT;
                    end else if (timeout_hit_s) begin
                        state_q        <= S_NEXT;
                    end else begin
                        wd_q           <= wd_d;
                    end
                end
                S_NEXT: begin
                    settle_q <= '0;
                    if (has_next_s) begin
                        mux_sel_q <= next_ch_s;
                        state_q   <= (SETTLE == 0) ? S_START : S_SETTLE;
                    end else begin
                        scan_done_q <= 1'b1;
                        if (scan_en_i && mask_nz_s) begin
                            mask_q    <= ch_mask_i;
                            mux_sel_q <= first_ch_s;
                            state_q   <= (SETTLE == 0) ? S_START : S_SETTLE;
                        end else begin
                            busy_q    <= 1'b0;
                            state_q   <= S_IDLE;
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign sar_start_o    = sar_start_q;
    assign mux_sel_o      = mux_sel_q;
    assign result_data_o  = result_data_q;
    assign result_ch_o    = result_ch_q;
    assign result_valid_o = result_valid_q;
    assign scan_done_o    = scan_done_q;
    assign busy_o         = busy_q;
    assign timeout_err_o  = timeout_err_q;

endmodule

// File: tb/tb_sar_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sar_scan_sequencer
//
// Bench for sar_scan_sequencer. A behavioural SAR answers each start pulse
// after a fixed number of cycles with a per-channel value (or never, for one
// chosen hung channel). Expected results are queued as each scenario is
// driven and popped when the sequencer publishes a result. A second instance
// built with a zero settle time is used for the start-latency check.
// ---------------------------------------------------------------------------
module tb_sar_scan_sequencer;

    localparam int N_CH    = 4;
    localparam int CH_W    = 2;
    localparam int DATA_W  = 8;
    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 63;
    localparam int C_CYC   = 18;
    localparam int PERIOD  = SETTLE + C_CYC + 3;

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] data;
    } res_t;

    logic              clk = 1'b0;
    logic              rst_n, trig, scan_en, err_clr, sar_eoc;
    logic [N_CH-1:0]   ch_mask;
    logic [DATA_W-1:0] sar_data;

    logic              sar_start, result_valid, scan_done, busy, timeout_err;
    logic [CH_W-1:0]   mux_sel, result_ch;
    logic [DATA_W-1:0] result_data;

    logic              z_sar_start, z_result_valid, z_scan_done, z_busy, z_timeout_err;
    logic [CH_W-1:0]   z_mux_sel, z_result_ch;
    logic [DATA_W-1:0] z_result_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_results = 0;
    res_t exp_q[$];

    logic [DATA_W-1:0] data_tbl [N_CH];
    int              sar_cnt = 0;
    int              hang_ch = -1;
    bit              spur_req = 1'b0;
    int              last_start_cyc = 0;
    int              last_start_ch = 0;
    logic [CH_W-1:0] conv_ch = '0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    sar_scan_sequencer #(
        .N_CH(N_CH), .CH_W(CH_W), .DATA_W(DATA_W), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
    ) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .trig_i(trig), .scan_en_i(scan_en),
        .ch_mask_i(ch_mask), .err_clr_i(err_clr), .sar_start_o(sar_start),
        .sar_eoc_i(sar_eoc), .sar_data_i(sar_data), .mux_sel_o(mux_sel),
        .result_data_o(result_data), .result_ch_o(result_ch),
        .result_valid_o(result_valid), .scan_done_o(scan_done),
        .busy_o(busy), .timeout_err_o(timeout_err)
    );

    sar_scan_sequencer #(
        .N_CH(N_CH), .CH_W(CH_W), .DATA_W(DATA_W), .SETTLE(0), .TIMEOUT(TIMEOUT)
    ) u_dut_s0 (
        .clk_i(clk), .rst_ni(rst_n), .trig_i(trig), .scan_en_i(scan_en),
        .ch_mask_i(ch_mask), .err_clr_i(err_clr), .sar_start_o(z_sar_start),
        .sar_eoc_i(sar_eoc), .sar_data_i(sar_data), .mux_sel_o(z_mux_sel),
        .result_data_o(z_result_data), .result_ch_o(z_result_ch),
        .result_valid_o(z_result_valid), .scan_done_o(z_scan_done),
        .busy_o(z_busy), .timeout_err_o(z_timeout_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int ch, input logic [DATA_W-1:0] d);
        res_t e;
        e.ch   = CH_W'(ch);
        e.data = d;
        exp_q.push_back(e);
    endtask

    function automatic logic sel_sig(input int which);
        case (which)
            0:       return result_valid;
            1:       return scan_done;
            2:       return sar_start;
            3:       return timeout_err;
            default: return 1'b0;
        endcase
    endfunction

    // Advance until the chosen output is seen high, giving up after `bound`.
    task automatic wait_sig(input int which, input int bound, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (sel_sig(which)) begin
                hit = 1'b1;
                break;
            end
        end
        check_eq(tag, 32'(hit), 32'd1);
    endtask

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_sar_start"},    32'(sar_start),    32'd0);
        check_eq({pfx, "_mux_sel"},      32'(mux_sel),      32'd0);
        check_eq({pfx, "_result_data"},  32'(result_data),  32'd0);
        check_eq({pfx, "_result_ch"},    32'(result_ch),    32'd0);
        check_eq({pfx, "_result_valid"}, 32'(result_valid), 32'd0);
        check_eq({pfx, "_scan_done"},    32'(scan_done),    32'd0);
        check_eq({pfx, "_busy"},         32'(busy),         32'd0);
        check_eq({pfx, "_timeout_err"},  32'(timeout_err),  32'd0);
    endtask

    // Behavioural SAR: sees the start pulse, answers C_CYC cycles later.
    initial begin
        sar_eoc  = 1'b0;
        sar_data = '0;
        forever begin
            @(posedge clk);
            #1;
            sar_eoc = 1'b0;
            if (sar_cnt > 0) begin
                sar_cnt--;
                if (sar_cnt == 0) begin
                    sar_eoc  = 1'b1;
                    sar_data = data_tbl[conv_ch];
                end
            end else if (sar_start == 1'b1) begin
                last_start_cyc = cyc;
                last_start_ch  = int'(mux_sel);
                conv_ch        = mux_sel;
                if (int'(mux_sel) != hang_ch) sar_cnt = C_CYC;
            end
            if (spur_req) begin
                sar_eoc  = 1'b1;
                sar_data = 8'hFF;
                spur_req = 1'b0;
            end
        end
    end

    // Result monitor: every published result must match the queue head.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (rst_n && result_valid) begin
                n_results++;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_result", 32'(result_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("res_ch",   32'(result_ch),   32'(e.ch));
                    check_eq("res_data", 32'(result_data), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int t_a;
        int rc0;
        bit activity;

        rst_n   = 1'b0;
        trig    = 1'b0;
        scan_en = 1'b0;
        err_clr = 1'b0;
        ch_mask = '0;
        data_tbl = '{8'h00, 8'hA5, 8'h00, 8'h3C};
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("rst");
        rst_n = 1'b1;
        tick();

        // Single scan over ch1 and ch3, with a spurious eoc while settling.
        push_exp(1, 8'hA5);
        push_exp(3, 8'h3C);
        ch_mask = 4'b1010;
        trig    = 1'b1;
        tick();
        trig     = 1'b0;
        spur_req = 1'b1;
        check_eq("t1_busy",        32'(busy),        32'd1);
        check_eq("t1_mux_first",   32'(mux_sel),     32'd1);
        check_eq("t1_start_e0",    32'(sar_start),   32'd0);
        check_eq("t1_s0_start_e0", 32'(z_sar_start), 32'd0);
        tick();
        check_eq("t1_s0_start_e1", 32'(z_sar_start), 32'd1);
        check_eq("t1_start_e1",    32'(sar_start),   32'd0);
        tick();
        check_eq("t1_start_e2",    32'(sar_start),   32'd0);
        tick();
        check_eq("t1_start_e3",    32'(sar_start),   32'd1);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        wait_sig(1, 200, "t1_done");
        check_eq("t1_busy_drop", 32'(busy),      32'd0);
        check_eq("t1_results",   32'(n_results), 32'd2);
        repeat (5) tick();
        check_eq("t1_trig_ignored", 32'(busy), 32'd0);

        // Continuous scanning of ch0; drop scan_en during the fourth conversion.
        data_tbl[0] = 8'h5A;
        repeat (4) push_exp(0, 8'h5A);
        ch_mask = 4'b0001;
        scan_en = 1'b1;
        wait_sig(0, 100, "t2_r1");
        t_a = cyc;
        wait_sig(0, 100, "t2_r2");
        check_eq("t2_period1", 32'(cyc - t_a), 32'(PERIOD));
        t_a = cyc;
        wait_sig(0, 100, "t2_r3");
        check_eq("t2_period2", 32'(cyc - t_a), 32'(PERIOD));
        wait_sig(2, 50, "t2_start4");
        tick();
        tick();
        scan_en = 1'b0;
        wait_sig(0, 100, "t2_r4");
        wait_sig(1, 10, "t2_done");
        check_eq("t2_idle", 32'(busy), 32'd0);

        // Watchdog: ch2 never answers, ch1 still produces its result.
        data_tbl[1] = 8'h11;
        push_exp(1, 8'h11);
        hang_ch = 2;
        rc0     = n_results;
        ch_mask = 4'b0110;
        trig    = 1'b1;
        tick();
        trig = 1'b0;
        wait_sig(3, 150, "t3_err_seen");
        check_eq("t3_err_ch",      32'(last_start_ch),        32'd2);
        check_eq("t3_err_latency", 32'(cyc - last_start_cyc), 32'(TIMEOUT));
        wait_sig(1, 10, "t3_done");
        check_eq("t3_results", 32'(n_results - rc0), 32'd1);
        repeat (5) tick();
        check_eq("t3_sticky", 32'(timeout_err), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("t3_cleared", 32'(timeout_err), 32'd0);

        // err_clr on the very cycle of a new timeout: the set wins.
        ch_mask = 4'b0100;
        trig    = 1'b1;
        tick();
        trig = 1'b0;
        wait_sig(2, 20, "t3b_start");
        repeat (TIMEOUT - 1) tick();
        check_eq("t3b_pre", 32'(timeout_err), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("t3b_set_wins", 32'(timeout_err), 32'd1);
        wait_sig(1, 10, "t3b_done");
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        hang_ch = -1;

        // Empty mask: a trigger must not start anything.
        ch_mask = 4'b0000;
        trig    = 1'b1;
        tick();
        trig     = 1'b0;
        activity = 1'b0;
        repeat (6) begin
            if (busy || sar_start) activity = 1'b1;
            tick();
        end
        check_eq("t4_mask0_idle", 32'(activity), 32'd0);

        // Mask change mid-pass: old mask finishes, new mask drives the next pass.
        data_tbl = '{8'h21, 8'h42, 8'h63, 8'h84};
        push_exp(0, 8'h21);
        push_exp(1, 8'h42);
        push_exp(3, 8'h84);
        ch_mask = 4'b0011;
        scan_en = 1'b1;
        wait_sig(0, 100, "t5_r0");
        ch_mask = 4'b1000;
        wait_sig(1, 100, "t5_pass1_done");
        check_eq("t5_relatch_ch", 32'(mux_sel), 32'd3);
        check_eq("t5_still_busy", 32'(busy),    32'd1);
        scan_en = 1'b0;
        wait_sig(1, 100, "t5_pass2_done");
        check_eq("t5_idle", 32'(busy), 32'd0);

        // Reset during a conversion, then restart from the lowest channel.
        ch_mask = 4'b0110;
        trig    = 1'b1;
        tick();
        trig = 1'b0;
        wait_sig(2, 20, "t6_start");
        repeat (5) tick();
        rc0   = n_results;
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_rst");
        tick();
        tick();
        rst_n = 1'b1;
        repeat (30) tick();
        check_eq("t6_no_result", 32'(n_results - rc0), 32'd0);
        push_exp(1, 8'h42);
        push_exp(2, 8'h63);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        check_eq("t6_restart_ch", 32'(mux_sel), 32'd1);
        wait_sig(1, 100, "t6_done");

        repeat (3) tick();
        check_eq("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
